// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter between ALU (A) and load (B) results, with a one-cycle registered
// register-file write port and a busy scoreboard of outstanding producers.
module regfile_wb_arbiter #(
  parameter int NREGS       = 32,
  parameter int ZERO_REG_RO = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_address_5,
  input  logic [31:0] a_data_32,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_address_5,
  input  logic [31:0] b_data_32,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd_5,
  input  logic [4:0]  rs1_5,
  input  logic [4:0]  rs2_5,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        w_en,
  output logic [4:0]  w_address_d_5,
  output logic [31:0] w_data_dval_32
);

  localparam logic PRIO_A = 1'b0;
  localparam logic PRIO_B = 1'b1;

  logic             prio_q, prio_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic             w_en_q, w_en_d;
  logic [4:0]       w_addr_q, w_addr_d;
  logic [31:0]      w_data_q, w_data_d;

  logic             a_fire, b_fire, xfer, zero_drop;
  logic [4:0]       xfer_addr;
  logic [31:0]      xfer_data;
  logic [NREGS-1:0] set_vec, clr_vec;

  always_comb begin
    // Ready is gated by reset so nothing can transfer or touch the scoreboard during reset.
    a_ready   = reset_n & a_valid & (~b_valid | (prio_q == PRIO_A));
    b_ready   = reset_n & b_valid & (~a_valid | (prio_q == PRIO_B));
    a_fire    = a_valid & a_ready;
    b_fire    = b_valid & b_ready;
    xfer      = a_fire | b_fire;
    xfer_addr = a_fire ? a_address_5 : b_address_5;
    xfer_data = a_fire ? a_data_32 : b_data_32;
    zero_drop = (ZERO_REG_RO != 0) && (xfer_addr == 5'd0);

    prio_d = prio_q;
    if (a_fire) begin
      prio_d = PRIO_B;
    end else if (b_fire) begin
      prio_d = PRIO_A;
    end

    w_en_d   = xfer & ~zero_drop;
    w_addr_d = xfer ? xfer_addr : w_addr_q;
    w_data_d = xfer ? xfer_data : w_data_q;

    clr_vec = '0;
    set_vec = '0;
    if (xfer) begin
      clr_vec[xfer_addr] = 1'b1;
    end
    if (issue_valid && !((ZERO_REG_RO != 0) && (issue_rd_5 == 5'd0))) begin
      set_vec[issue_rd_5] = 1'b1;
    end
    // Set applied after clear: a newly issued producer outlives the older writeback.
    busy_d = (busy_q & ~clr_vec) | set_vec;

    if (!reset_n) begin
      prio_d   = PRIO_A;
      busy_d   = '0;
      w_en_d   = 1'b0;
      w_addr_d = 5'd0;
      w_data_d = 32'd0;
    end
  end

  always_ff @(posedge clock) begin
    prio_q   <= prio_d;
    busy_q   <= busy_d;
    w_en_q   <= w_en_d;
    w_addr_q <= w_addr_d;
    w_data_q <= w_data_d;
  end

  always_comb begin
    rs1_busy       = busy_q[rs1_5] & ~((ZERO_REG_RO != 0) && (rs1_5 == 5'd0));
    rs2_busy       = busy_q[rs2_5] & ~((ZERO_REG_RO != 0) && (rs2_5 == 5'd0));
    w_en           = w_en_q;
    w_address_d_5  = w_addr_q;
    w_data_dval_32 = w_data_q;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter: one vector per clock cycle,
// plus a hand-written contention sequence and a requester-stability monitor.
module tb_regfile_wb_arbiter;

  logic        clock;
  logic        reset_n;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_address_5, b_address_5;
  logic [31:0] a_data_32, b_data_32;
  logic        issue_valid;
  logic [4:0]  issue_rd_5, rs1_5, rs2_5;
  logic        rs1_busy, rs2_busy, w_en;
  logic [4:0]  w_address_d_5;
  logic [31:0] w_data_dval_32;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.NREGS(32), .ZERO_REG_RO(1)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_address_5(a_address_5), .a_data_32(a_data_32),
    .b_valid(b_valid), .b_ready(b_ready), .b_address_5(b_address_5), .b_data_32(b_data_32),
    .issue_valid(issue_valid), .issue_rd_5(issue_rd_5),
    .rs1_5(rs1_5), .rs2_5(rs2_5), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .w_en(w_en), .w_address_d_5(w_address_d_5), .w_data_dval_32(w_data_dval_32)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        rst_n;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        exp_ar;
    logic        exp_br;
    logic        exp_wen;
    logic        chk_w;
    logic [4:0]  exp_wa;
    logic [31:0] exp_wd;
    logic        exp_r1b;
    logic        exp_r2b;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset_n     = v.rst_n;
    a_valid     = v.av;
    a_address_5 = v.aa;
    a_data_32   = v.ad;
    b_valid     = v.bv;
    b_address_5 = v.ba;
    b_data_32   = v.bd;
    issue_valid = v.iv;
    issue_rd_5  = v.ird;
    rs1_5       = v.rs1;
    rs2_5       = v.rs2;
  endtask

  // A stalled requester must present identical valid/address/data on the next cycle.
  logic        pend_a, pend_b;
  logic [4:0]  snap_aa, snap_ba;
  logic [31:0] snap_ad, snap_bd;
  initial begin
    pend_a = 1'b0;
    pend_b = 1'b0;
    snap_aa = '0; snap_ba = '0; snap_ad = '0; snap_bd = '0;
  end
  always @(negedge clock) begin
    if (pend_a) begin
      checkOutput("stall_hold_a", {a_valid, a_address_5, a_data_32[25:0]}, {1'b1, snap_aa, snap_ad[25:0]});
      checkOutput("stall_hold_a_hi", {26'd0, a_data_32[31:26]}, {26'd0, snap_ad[31:26]});
    end
    if (pend_b) begin
      checkOutput("stall_hold_b", {b_valid, b_address_5, b_data_32[25:0]}, {1'b1, snap_ba, snap_bd[25:0]});
      checkOutput("stall_hold_b_hi", {26'd0, b_data_32[31:26]}, {26'd0, snap_bd[31:26]});
    end
    pend_a  = reset_n & a_valid & ~a_ready;
    pend_b  = reset_n & b_valid & ~b_ready;
    snap_aa = a_address_5; snap_ad = a_data_32;
    snap_ba = b_address_5; snap_bd = b_data_32;
  end

  logic got_a, got_b;
  int   n_grants;
  logic first_is_b, second_is_b;

  initial begin
    // rst av aa ad bv ba bd iv ird rs1 rs2 | ar br wen chkw wa wd r1b r2b
    vecs[0]  = '{1'b0, 1'b1, 5'd3,  32'h0,    1'b1, 5'd4,  32'h0,    1'b0, 5'd0,  5'd7,  5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  32'h0,    1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 5'd3,  32'h0,    1'b1, 5'd4,  32'h0,    1'b1, 5'd7,  5'd7,  5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  32'h0,    1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 5'd5,  32'h1234, 1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  5'd5,  5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5,  32'h1234, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  5'd5,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  32'h1234, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 5'd0,  32'h0,    1'b1, 5'd9,  32'h99,   1'b0, 5'd0,  5'd9,  5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd9,  32'h99,   1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 5'd3,  32'hA,    1'b1, 5'd4,  32'hB,    1'b0, 5'd0,  5'd3,  5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3,  32'hA,    1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 5'd3,  32'hA1,   1'b1, 5'd4,  32'hB,    1'b0, 5'd0,  5'd3,  5'd4, 1'b0, 1'b1, 1'b1, 1'b1, 5'd4,  32'hB,    1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 5'd3,  32'hA1,   1'b1, 5'd4,  32'hB1,   1'b0, 5'd0,  5'd3,  5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3,  32'hA1,   1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 5'd3,  32'hA2,   1'b1, 5'd4,  32'hB1,   1'b0, 5'd0,  5'd3,  5'd4, 1'b0, 1'b1, 1'b1, 1'b1, 5'd4,  32'hB1,   1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 5'd3,  32'hA2,   1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  5'd3,  5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3,  32'hA2,   1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3,  32'hA2,   1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b1, 5'd7,  5'd7,  5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3,  32'hA2,   1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 5'd0,  32'h0,    1'b1, 5'd7,  32'h77,   1'b0, 5'd0,  5'd7,  5'd4, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7,  32'h77,   1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 5'd0,  32'h0,    1'b1, 5'd7,  32'h78,   1'b1, 5'd7,  5'd7,  5'd4, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7,  32'h78,   1'b1, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b1, 5'd7,  5'd7,  5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7,  32'h78,   1'b1, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 5'd0,  32'h0,    1'b1, 5'd7,  32'h79,   1'b0, 5'd0,  5'd7,  5'd4, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7,  32'h79,   1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 5'd8,  32'h88,   1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  5'd7,  5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8,  32'h88,   1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b1, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8,  32'h88,   1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b1, 5'd0,  32'hFF,   1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  5'd0,  5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,    1'b0, 1'b0};
    vecs[19] = '{1'b1, 1'b1, 5'd10, 32'h10,   1'b0, 5'd0,  32'h0,    1'b1, 5'd12, 5'd12, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 32'h10,   1'b1, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 5'd10, 32'h10,   1'b1, 5'd11, 32'h11,   1'b0, 5'd0,  5'd12, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  32'h0,    1'b0, 1'b0};
    vecs[21] = '{1'b1, 1'b1, 5'd10, 32'h20,   1'b1, 5'd11, 32'h21,   1'b0, 5'd0,  5'd12, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 32'h20,   1'b0, 1'b0};
    vecs[22] = '{1'b1, 1'b0, 5'd0,  32'h0,    1'b1, 5'd11, 32'h21,   1'b0, 5'd0,  5'd12, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd11, 32'h21,   1'b0, 1'b0};

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      #2;
      checkOutput($sformatf("v%0d_a_ready", i), {31'd0, a_ready}, {31'd0, vecs[i].exp_ar});
      checkOutput($sformatf("v%0d_b_ready", i), {31'd0, b_ready}, {31'd0, vecs[i].exp_br});
      @(posedge clock);
      #1;
      checkOutput($sformatf("v%0d_w_en", i), {31'd0, w_en}, {31'd0, vecs[i].exp_wen});
      if (vecs[i].chk_w) begin
        checkOutput($sformatf("v%0d_w_addr", i), {27'd0, w_address_d_5}, {27'd0, vecs[i].exp_wa});
        checkOutput($sformatf("v%0d_w_data", i), w_data_dval_32, vecs[i].exp_wd);
      end
      checkOutput($sformatf("v%0d_rs1_busy", i), {31'd0, rs1_busy}, {31'd0, vecs[i].exp_r1b});
      checkOutput($sformatf("v%0d_rs2_busy", i), {31'd0, rs2_busy}, {31'd0, vecs[i].exp_r2b});
    end

    // Both requesters raised together with A favoured: expect A then B, each dropping valid once granted.
    issue_valid = 1'b0;
    a_valid = 1'b1; a_address_5 = 5'd1; a_data_32 = 32'h101;
    b_valid = 1'b1; b_address_5 = 5'd2; b_data_32 = 32'h202;
    n_grants = 0;
    first_is_b = 1'b0;
    second_is_b = 1'b0;
    for (int c = 0; c < 4 && (a_valid || b_valid); c++) begin
      #2;
      got_a = a_ready;
      got_b = b_ready;
      checkOutput($sformatf("fair_c%0d_one_grant", c), {31'd0, got_a & got_b}, 32'd0);
      @(posedge clock);
      #1;
      if (got_a || got_b) begin
        if (n_grants == 0) first_is_b = got_b;
        else second_is_b = got_b;
        n_grants++;
        checkOutput($sformatf("fair_c%0d_w_en", c), {31'd0, w_en}, 32'd1);
        checkOutput($sformatf("fair_c%0d_w_addr", c), {27'd0, w_address_d_5}, got_b ? 32'd2 : 32'd1);
        if (got_a) a_valid = 1'b0;
        else b_valid = 1'b0;
      end
    end
    checkOutput("fair_done_in_budget", {31'd0, a_valid | b_valid}, 32'd0);
    checkOutput("fair_grant_count", n_grants, 32'd2);
    checkOutput("fair_first_is_a", {31'd0, first_is_b}, 32'd0);
    checkOutput("fair_second_is_b", {31'd0, second_is_b}, 32'd1);
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("fair_idle_w_en", {31'd0, w_en}, 32'd0);
    checkOutput("fair_idle_w_data_hold", w_data_dval_32, 32'h202);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: NREGS, 32, number of architectural registers tracked; fixed at 32, matching the 5-bit register address.
REQ-002 Parameter: ZERO_REG_RO, 1, when 1 writes to register 0 are accepted but dropped and register 0 is never marked busy.
REQ-003 Port: clock  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset_n  input  1  reset, synchronous, active-low.
REQ-005 Port: a_valid / a_ready  input / output  1 / 1  ALU writeback handshake.
REQ-006 Port: a_address_5 / a_data_32  input  5 / 32  ALU destination register and value.
REQ-007 Port: b_valid / b_ready  input / output  1 / 1  memory-load writeback handshake.
REQ-008 Port: b_address_5 / b_data_32  input  5 / 32  load destination register and value.
REQ-009 Port: issue_valid / issue_rd_5  input  1 / 5  an instruction issued that will write register issue_rd_5.
REQ-010 Port: rs1_5 / rs2_5  input  5 / 5  source registers being read by decode.
REQ-011 Port: rs1_busy / rs2_busy  output  1 / 1  source register has a write outstanding.
REQ-012 Port: w_en / w_address_d_5 / w_data_dval_32  output  1 / 5 / 32  register-file write port, registered.

Function
REQ-013 Transfer on a requester SHALL occur in a cycle where its valid and ready are both high at the rising edge.
REQ-014 At most one requester SHALL be granted per cycle.
REQ-015 Readiness: only one valid -> that requester's ready = 1. Both valid -> only the favoured requester's ready = 1. Neither valid -> a_ready = b_ready = 0.
REQ-016 Favoured pointer prio (0 = A, 1 = B) SHALL resets to A and, after every transfer, point at the requester not granted.
REQ-017 A requester SHALL hold valid, address and data stable until transfer; the bench SHALL flag any change while valid=1 and ready=0.
REQ-018 Write latency SHALL be exactly one cycle: transfer at edge N -> w_en=1 with the transferred address/data during cycle N+1.
REQ-019 w_en SHALL be 0 in any cycle that follows an edge with no transfer; w_address_d_5 and w_data_dval_32 SHALL hold their last values.
REQ-020 With ZERO_REG_RO=1, a transfer to register 0 SHALL complete the handshake but SHALL produce w_en=0.
REQ-021 The scoreboard SHALL be a 32-bit busy vector.
REQ-022 On issue_valid=1, busy[issue_rd_5] SHALL be set at the edge (except register 0 when ZERO_REG_RO=1).
REQ-023 On a transfer, busy[address] SHALL be cleared at the same edge the transfer occurs.
REQ-024 If a set and a clear hit the same register at one edge, set SHALL win, because a newer producer is now outstanding.
REQ-025 A set to an already-busy register SHALL leave it busy; the scoreboard SHALL NOT count multiple outstanding producers.
REQ-026 A transfer to a non-busy register SHALL still be written, with no error.
REQ-027 rs1_busy = busy[rs1_5] and rs2_busy = busy[rs2_5], both combinational from the registered vector with no bypass of same-cycle set or clear.
REQ-028 Register 0 SHALL always report not busy when ZERO_REG_RO=1.

Reset
REQ-029 While reset_n=0 at an edge, the block SHALL load: busy=0, prio=A, w_en=0, w_address_d_5=0, w_data_dval_32=0.
REQ-030 While reset_n=0, a_ready and b_ready SHALL be forced to 0, so no transfer or scoreboard update can occur.
REQ-031 A transfer that occurred before reset SHALL still have its w_en suppressed if reset is sampled at the following edge.
REQ-032 After release, the first edge with reset_n=1 SHALL operate normally.

Verification
REQ-033 Reset: hold reset_n=0 for 2 cycles with a_valid=b_valid=1 -> a_ready=b_ready=0, w_en=0, rs1_busy=rs2_busy=0.
REQ-034 Single ALU write: a_valid=1, a_address_5=5, a_data_32=0x1234 for one cycle after reset -> next cycle w_en=1, w_address_d_5=5, w_data_dval_32=0x1234; the cycle after, w_en=0.
REQ-035 Contention: a_valid and b_valid held for 4 cycles (A->r3 0xA, B->r4 0xB, both stall-holding, new data after each grant) -> grants A, B, A, B; w_en=1 every cycle from cycle 2.
REQ-036 Scoreboard: issue r7 -> rs1_5=7 shows busy the next cycle. B writes r7 -> busy clears the cycle after transfer. Issue r7 on the same edge as the B transfer -> r7 stays busy.
REQ-037 Register 0: issue r0 and then A writes r0 value 0xFF -> a_ready=1, w_en stays 0, busy[0] never set.
REQ-038 Mid-operation reset: A transfer at edge N, reset_n=0 sampled at edge N+1 -> w_en=0 after N+1, busy=0, prio=A.
